// File: rtl/arbitro_prioridad_if.sv
// Bus between the fixed-priority arbiter and its four input / four output FIFOs.
// The master modport is the arbiter's view; slave is the surrounding FIFO side.
interface arbitro_prioridad_if #(
   parameter int DW = 10
);
   logic          active;
   logic [DW-1:0] fifo_data_in0;
   logic [DW-1:0] fifo_data_in1;
   logic [DW-1:0] fifo_data_in2;
   logic [DW-1:0] fifo_data_in3;
   logic          empty0;
   logic          empty1;
   logic          empty2;
   logic          empty3;
   logic          almost_full4;
   logic          almost_full5;
   logic          almost_full6;
   logic          almost_full7;
   logic          pop0;
   logic          pop1;
   logic          pop2;
   logic          pop3;
   logic          push4;
   logic          push5;
   logic          push6;
   logic          push7;
   logic [DW-1:0] data_out;
   logic          idle;

   modport master (
      input  active,
      input  fifo_data_in0, fifo_data_in1, fifo_data_in2, fifo_data_in3,
      input  empty0, empty1, empty2, empty3,
      input  almost_full4, almost_full5, almost_full6, almost_full7,
      output pop0, pop1, pop2, pop3,
      output push4, push5, push6, push7,
      output data_out, idle
   );

   modport slave (
      output active,
      output fifo_data_in0, fifo_data_in1, fifo_data_in2, fifo_data_in3,
      output empty0, empty1, empty2, empty3,
      output almost_full4, almost_full5, almost_full6, almost_full7,
      input  pop0, pop1, pop2, pop3,
      input  push4, push5, push6, push7,
      input  data_out, idle
   );
endinterface

// File: rtl/arbitro_prioridad.sv
// Fixed-priority (0 > 1 > 2 > 3) 4-to-4 router: pops one eligible input word per
// cycle and pushes it, one cycle later, to the output FIFO named by its top two bits.
module arbitro_prioridad #(
   parameter int DW = 10
) (
   input  logic                clk,
   input  logic                reset,
   arbitro_prioridad_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVE   = 2'd1,
      ST_BLOCKED = 2'd2
   } state_t;

   logic [DW-1:0] head_s [4];
   logic [1:0]    dest_s [4];
   logic [3:0]    empty_s;
   logic [3:0]    af_s;
   logic [3:0]    eligible_s;
   logic [3:0]    grant_s;
   logic [1:0]    grant_idx_s;
   logic [DW-1:0] grant_word_s;
   logic [1:0]    grant_dest_s;

   state_t        state_r;
   logic [3:0]    push_r;
   logic [DW-1:0] data_out_r;

   assign head_s[0] = bus.fifo_data_in0;
   assign head_s[1] = bus.fifo_data_in1;
   assign head_s[2] = bus.fifo_data_in2;
   assign head_s[3] = bus.fifo_data_in3;
   assign empty_s   = {bus.empty3, bus.empty2, bus.empty1, bus.empty0};
   assign af_s      = {bus.almost_full7, bus.almost_full6, bus.almost_full5, bus.almost_full4};

   // Eligibility: almost_full is checked combinationally, so a flag rising this cycle blocks this grant.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         dest_s[i]     = head_s[i][DW-1 -: 2];
         eligible_s[i] = bus.active & ~reset & ~empty_s[i] & ~af_s[dest_s[i]];
      end
   end

   // Priority select over eligible inputs only, so a blocked input never stalls a lower one.
   always_comb begin
      grant_s     = 4'b0000;
      grant_idx_s = 2'd0;
      if (eligible_s[0]) begin
         grant_s     = 4'b0001;
         grant_idx_s = 2'd0;
      end else if (eligible_s[1]) begin
         grant_s     = 4'b0010;
         grant_idx_s = 2'd1;
      end else if (eligible_s[2]) begin
         grant_s     = 4'b0100;
         grant_idx_s = 2'd2;
      end else if (eligible_s[3]) begin
         grant_s     = 4'b1000;
         grant_idx_s = 2'd3;
      end else begin
         grant_s     = 4'b0000;
         grant_idx_s = 2'd0;
      end
   end

   assign grant_word_s = head_s[grant_idx_s];
   assign grant_dest_s = dest_s[grant_idx_s];

   assign bus.pop0 = grant_s[0];
   assign bus.pop1 = grant_s[1];
   assign bus.pop2 = grant_s[2];
   assign bus.pop3 = grant_s[3];

   // Capture stage and FSM; an in-flight word never gates a new grant, the almost-full margin covers it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         push_r     <= 4'b0000;
         data_out_r <= '0;
      end else if (|grant_s) begin
         state_r    <= ST_SERVE;
         push_r     <= 4'b0001 << grant_dest_s;
         data_out_r <= grant_word_s;
      end else if (~&empty_s) begin
         state_r    <= ST_BLOCKED;
         push_r     <= 4'b0000;
         data_out_r <= data_out_r;
      end else begin
         state_r    <= ST_IDLE;
         push_r     <= 4'b0000;
         data_out_r <= data_out_r;
      end
   end

   assign bus.push4    = push_r[0];
   assign bus.push5    = push_r[1];
   assign bus.push6    = push_r[2];
   assign bus.push7    = push_r[3];
   assign bus.data_out = data_out_r;
   // Pure decode of flops: low whenever a push is still going out.
   assign bus.idle     = (state_r == ST_IDLE) && (push_r == 4'b0000);

endmodule

// File: tb/tb_arbitro_prioridad.sv
// Directed bench for arbitro_prioridad: inputs change 1ns after each rising edge,
// pops are sampled 1ns later, registered outputs 1ns after the following edge.
module tb_arbitro_prioridad;

   logic clk = 1'b0;
   logic reset;
   int   nvec = 0;
   int   nerr = 0;

   arbitro_prioridad_if #(.DW(10)) bus ();
   arbitro_prioridad #(.DW(10)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [3:0] pop_v();
      return {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
   endfunction

   function automatic logic [3:0] push_v();
      return {bus.push7, bus.push6, bus.push5, bus.push4};
   endfunction

   task automatic set_in(input int i, input logic [9:0] w, input logic e);
      case (i)
         0: begin bus.fifo_data_in0 = w; bus.empty0 = e; end
         1: begin bus.fifo_data_in1 = w; bus.empty1 = e; end
         2: begin bus.fifo_data_in2 = w; bus.empty2 = e; end
         3: begin bus.fifo_data_in3 = w; bus.empty3 = e; end
         default: ;
      endcase
   endtask

   task automatic set_af(input logic [3:0] a);
      {bus.almost_full7, bus.almost_full6, bus.almost_full5, bus.almost_full4} = a;
   endtask

   task automatic all_empty();
      for (int i = 0; i < 4; i++) set_in(i, 10'h000, 1'b1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.active = 1'b1; set_af(4'b0000);
      for (int i = 0; i < 4; i++) set_in(i, 10'h0F0 + 10'(i), 1'b0);
      #1;
      nvec++; if (pop_v() !== 4'b0000) begin nerr++; $display("FAIL reset_pop: got %b expected 0000", pop_v()); end
      tick();
      nvec++; if (push_v() !== 4'b0000) begin nerr++; $display("FAIL reset_push: got %b expected 0000", push_v()); end
      nvec++; if (bus.data_out !== 10'h000) begin nerr++; $display("FAIL reset_data: got %h expected 000", bus.data_out); end
      nvec++; if (bus.idle !== 1'b1) begin nerr++; $display("FAIL reset_idle: got %b expected 1", bus.idle); end
      reset = 1'b0; all_empty();
      #1;
      nvec++; if (pop_v() !== 4'b0000) begin nerr++; $display("FAIL empty_pop: got %b expected 0000", pop_v()); end
      tick();
      nvec++; if (push_v() !== 4'b0000) begin nerr++; $display("FAIL empty_push: got %b expected 0000", push_v()); end
      nvec++; if (bus.idle !== 1'b1) begin nerr++; $display("FAIL empty_idle: got %b expected 1", bus.idle); end
      nvec++; if (bus.data_out !== 10'h000) begin nerr++; $display("FAIL empty_data: got %h expected 000", bus.data_out); end
   endtask

   task automatic test_priority();
      logic [9:0] w [4];
      w[0] = 10'h001; w[1] = 10'h101; w[2] = 10'h201; w[3] = 10'h301;
      for (int i = 0; i < 4; i++) set_in(i, w[i], 1'b0);
      for (int k = 0; k < 4; k++) begin
         #1;
         nvec++; if (pop_v() !== (4'b0001 << k)) begin nerr++; $display("FAIL prio_pop%0d: got %b expected %b", k, pop_v(), 4'b0001 << k); end
         tick();
         set_in(k, 10'h000, 1'b1);
         nvec++; if (push_v() !== (4'b0001 << k)) begin nerr++; $display("FAIL prio_push%0d: got %b expected %b", k, push_v(), 4'b0001 << k); end
         nvec++; if (bus.data_out !== w[k]) begin nerr++; $display("FAIL prio_data%0d: got %h expected %h", k, bus.data_out, w[k]); end
         nvec++; if (bus.idle !== 1'b0) begin nerr++; $display("FAIL prio_idle%0d: got %b expected 0", k, bus.idle); end
      end
      tick();
      nvec++; if (push_v() !== 4'b0000) begin nerr++; $display("FAIL prio_push_end: got %b expected 0000", push_v()); end
      nvec++; if (bus.idle !== 1'b1) begin nerr++; $display("FAIL prio_idle_end: got %b expected 1", bus.idle); end
   endtask

   task automatic test_no_hol();
      set_in(0, 10'h101, 1'b0); set_in(1, 10'h002, 1'b0); set_af(4'b0010);
      #1;
      nvec++; if (pop_v() !== 4'b0010) begin nerr++; $display("FAIL hol_pop1: got %b expected 0010", pop_v()); end
      tick();
      set_in(1, 10'h000, 1'b1);
      nvec++; if (push_v() !== 4'b0001) begin nerr++; $display("FAIL hol_push4: got %b expected 0001", push_v()); end
      nvec++; if (bus.data_out !== 10'h002) begin nerr++; $display("FAIL hol_data002: got %h expected 002", bus.data_out); end
      #1;
      nvec++; if (pop_v() !== 4'b0000) begin nerr++; $display("FAIL hol_blocked_pop: got %b expected 0000", pop_v()); end
      tick();
      nvec++; if (push_v() !== 4'b0000) begin nerr++; $display("FAIL hol_nogrant_push: got %b expected 0000", push_v()); end
      nvec++; if (bus.data_out !== 10'h002) begin nerr++; $display("FAIL hol_hold_data: got %h expected 002", bus.data_out); end
      nvec++; if (bus.idle !== 1'b0) begin nerr++; $display("FAIL hol_blocked_idle: got %b expected 0", bus.idle); end
      set_af(4'b0000);
      #1;
      nvec++; if (pop_v() !== 4'b0001) begin nerr++; $display("FAIL hol_pop0: got %b expected 0001", pop_v()); end
      tick();
      set_in(0, 10'h000, 1'b1);
      nvec++; if (push_v() !== 4'b0010) begin nerr++; $display("FAIL hol_push5: got %b expected 0010", push_v()); end
      nvec++; if (bus.data_out !== 10'h101) begin nerr++; $display("FAIL hol_data101: got %h expected 101", bus.data_out); end
      tick();
      nvec++; if (bus.idle !== 1'b1) begin nerr++; $display("FAIL hol_idle_end: got %b expected 1", bus.idle); end
   endtask

   task automatic test_af_same_cycle();
      set_in(0, 10'h080, 1'b0); set_in(2, 10'h1C3, 1'b0); set_af(4'b0001);
      #1;
      nvec++; if (pop_v() !== 4'b0100) begin nerr++; $display("FAIL afnow_pop2: got %b expected 0100", pop_v()); end
      tick();
      set_in(2, 10'h000, 1'b1); set_af(4'b0000);
      nvec++; if (push_v() !== 4'b0010) begin nerr++; $display("FAIL afnow_push5: got %b expected 0010", push_v()); end
      nvec++; if (bus.data_out !== 10'h1C3) begin nerr++; $display("FAIL afnow_data: got %h expected 1c3", bus.data_out); end
      #1;
      nvec++; if (pop_v() !== 4'b0001) begin nerr++; $display("FAIL afnow_pop0: got %b expected 0001", pop_v()); end
      tick();
      set_in(0, 10'h000, 1'b1);
      nvec++; if (push_v() !== 4'b0001) begin nerr++; $display("FAIL afnow_push4: got %b expected 0001", push_v()); end
      nvec++; if (bus.data_out !== 10'h080) begin nerr++; $display("FAIL afnow_data080: got %h expected 080", bus.data_out); end
      tick();
   endtask

   task automatic test_back_to_back();
      set_in(0, 10'h011, 1'b0);
      #1;
      nvec++; if (pop_v() !== 4'b0001) begin nerr++; $display("FAIL b2b_pop_a: got %b expected 0001", pop_v()); end
      tick();
      set_in(0, 10'h022, 1'b0);
      nvec++; if (push_v() !== 4'b0001) begin nerr++; $display("FAIL b2b_push_a: got %b expected 0001", push_v()); end
      nvec++; if (bus.data_out !== 10'h011) begin nerr++; $display("FAIL b2b_data_a: got %h expected 011", bus.data_out); end
      #1;
      nvec++; if (pop_v() !== 4'b0001) begin nerr++; $display("FAIL b2b_pop_b: got %b expected 0001", pop_v()); end
      tick();
      set_in(0, 10'h000, 1'b1);
      nvec++; if (push_v() !== 4'b0001) begin nerr++; $display("FAIL b2b_push_b: got %b expected 0001", push_v()); end
      nvec++; if (bus.data_out !== 10'h022) begin nerr++; $display("FAIL b2b_data_b: got %h expected 022", bus.data_out); end
      tick();
   endtask

   task automatic test_all_combos();
      int         ptr [4];
      int         g;
      logic [9:0] exp_w;
      logic [1:0] d;
      for (int i = 0; i < 4; i++) ptr[i] = 0;
      for (int t = 0; t < 16; t++) begin
         for (int i = 0; i < 4; i++) begin
            d = 2'((i + ptr[i]) % 4);
            if (ptr[i] < 4) set_in(i, {d, 8'(i * 16 + ptr[i])}, 1'b0);
            else            set_in(i, 10'h000, 1'b1);
         end
         g = 0;
         while (ptr[g] >= 4) g++;
         d     = 2'((g + ptr[g]) % 4);
         exp_w = {d, 8'(g * 16 + ptr[g])};
         ptr[g]++;
         #1;
         nvec++; if (pop_v() !== (4'b0001 << g)) begin nerr++; $display("FAIL combo_pop%0d: got %b expected %b", t, pop_v(), 4'b0001 << g); end
         tick();
         nvec++; if (push_v() !== (4'b0001 << exp_w[9:8])) begin nerr++; $display("FAIL combo_push%0d: got %b expected %b", t, push_v(), 4'b0001 << exp_w[9:8]); end
         nvec++; if (bus.data_out !== exp_w) begin nerr++; $display("FAIL combo_data%0d: got %h expected %h", t, bus.data_out, exp_w); end
      end
      all_empty();
      tick();
      nvec++; if (push_v() !== 4'b0000) begin nerr++; $display("FAIL combo_push_end: got %b expected 0000", push_v()); end
      nvec++; if (bus.idle !== 1'b1) begin nerr++; $display("FAIL combo_idle_end: got %b expected 1", bus.idle); end
   endtask

   task automatic test_active_drop();
      set_in(0, 10'h3FF, 1'b0);
      #1;
      nvec++; if (pop_v() !== 4'b0001) begin nerr++; $display("FAIL act_pop_3ff: got %b expected 0001", pop_v()); end
      tick();
      set_in(0, 10'h055, 1'b0); bus.active = 1'b0;
      nvec++; if (push_v() !== 4'b1000) begin nerr++; $display("FAIL act_push7: got %b expected 1000", push_v()); end
      nvec++; if (bus.data_out !== 10'h3FF) begin nerr++; $display("FAIL act_data3ff: got %h expected 3ff", bus.data_out); end
      #1;
      nvec++; if (pop_v() !== 4'b0000) begin nerr++; $display("FAIL act_off_pop: got %b expected 0000", pop_v()); end
      tick();
      nvec++; if (push_v() !== 4'b0000) begin nerr++; $display("FAIL act_off_push: got %b expected 0000", push_v()); end
      nvec++; if (bus.idle !== 1'b0) begin nerr++; $display("FAIL act_off_idle: got %b expected 0", bus.idle); end
      tick();
      nvec++; if (pop_v() !== 4'b0000) begin nerr++; $display("FAIL act_off_pop2: got %b expected 0000", pop_v()); end
      nvec++; if (bus.idle !== 1'b0) begin nerr++; $display("FAIL act_off_idle2: got %b expected 0", bus.idle); end
      bus.active = 1'b1;
      #1;
      nvec++; if (pop_v() !== 4'b0001) begin nerr++; $display("FAIL act_on_pop: got %b expected 0001", pop_v()); end
      tick();
      set_in(0, 10'h000, 1'b1);
      nvec++; if (push_v() !== 4'b0001) begin nerr++; $display("FAIL act_on_push4: got %b expected 0001", push_v()); end
      nvec++; if (bus.data_out !== 10'h055) begin nerr++; $display("FAIL act_on_data: got %h expected 055", bus.data_out); end
      tick();
   endtask

   task automatic test_reset_inflight();
      // reset during the pop cycle: nothing is captured
      set_in(2, 10'h2AA, 1'b0); reset = 1'b1;
      #1;
      nvec++; if (pop_v() !== 4'b0000) begin nerr++; $display("FAIL rst_pop2: got %b expected 0000", pop_v()); end
      tick();
      reset = 1'b0;
      nvec++; if (push_v() !== 4'b0000) begin nerr++; $display("FAIL rst_push6: got %b expected 0000", push_v()); end
      nvec++; if (bus.data_out !== 10'h000) begin nerr++; $display("FAIL rst_data: got %h expected 000", bus.data_out); end
      nvec++; if (bus.idle !== 1'b1) begin nerr++; $display("FAIL rst_idle: got %b expected 1", bus.idle); end
      // word captured, reset lands on the edge that would clear its push
      #1;
      nvec++; if (pop_v() !== 4'b0100) begin nerr++; $display("FAIL rst2_pop2: got %b expected 0100", pop_v()); end
      tick();
      set_in(2, 10'h000, 1'b1); reset = 1'b1;
      nvec++; if (push_v() !== 4'b0100) begin nerr++; $display("FAIL rst2_push6: got %b expected 0100", push_v()); end
      tick();
      reset = 1'b0;
      nvec++; if (push_v() !== 4'b0000) begin nerr++; $display("FAIL rst2_push_clr: got %b expected 0000", push_v()); end
      nvec++; if (bus.data_out !== 10'h000) begin nerr++; $display("FAIL rst2_data: got %h expected 000", bus.data_out); end
   endtask

   initial begin
      reset = 1'b1;
      bus.active = 1'b0;
      set_af(4'b0000);
      all_empty();
      test_reset();
      test_priority();
      test_no_hol();
      test_af_same_cycle();
      test_back_to_back();
      test_all_combos();
      test_active_drop();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/arbitro_prioridad.md
ARBITRO_PRIORIDAD -- requirements
Module: arbitro_prioridad

Interface
REQ-001 The block SHALL have parameter DW, default 10, meaning the word width; bits [DW-1:DW-2] are the destination index.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port active, input, 1, high while the main state machine is in ACTIVE; arbitration is allowed only when high.
REQ-005 The block SHALL have ports fifo_data_in0..3, input, DW each, head word of input FIFO 0..3 (show-ahead, valid while not empty).
REQ-006 The block SHALL have ports empty0..3, input, 1 each, input FIFO 0..3 empty.
REQ-007 The block SHALL have ports almost_full4..7, input, 1 each, output FIFO 4..7 almost full.
REQ-008 The block SHALL have ports pop0..3, output, 1 each, combinational read strobe to input FIFO 0..3.
REQ-009 The block SHALL have ports push4..7, output, 1 each, registered write strobe to output FIFO 4..7.
REQ-010 The block SHALL have port data_out, output, DW, registered word shared by all output FIFOs.
REQ-011 The block SHALL have port idle, output, 1, registered: all input FIFOs empty and nothing in flight.

Function
REQ-012 Input i SHALL be eligible when active=1, reset=0, empty_i=0, and almost_full of output (4 + fifo_data_in_i[DW-1:DW-2]) = 0.
REQ-013 Priority SHALL be fixed: 0 > 1 > 2 > 3; the lowest-index eligible input is granted.
REQ-014 At most one pop SHALL be asserted per cycle; pop_i = 1 exactly when input i is granted that cycle.
REQ-015 Input i SHALL NOT be granted if a higher-index input is eligible and i is not; a blocked higher-priority input does not stop lower ones (no head-of-line blocking across inputs).
REQ-016 Granted word SHALL be captured into data_out on the same edge; push_(4+dest) SHALL be 1 in the following cycle only; latency pop -> push is 1 cycle.
REQ-017 Other push lines SHALL be 0; with no grant, all push lines are 0 next cycle and data_out holds its last value.
REQ-018 Sustained throughput SHALL be one word per cycle while any input is eligible.
REQ-019 If a word to output d is in flight (push_d asserting next cycle) and almost_full_d is 0, the in-flight word SHALL NOT block a new grant to d; almost-full threshold carries the margin.
REQ-020 The internal FSM SHALL have states IDLE (no input non-empty), SERVE (grant issued this cycle), BLOCKED (some input non-empty but none eligible).
REQ-021 Transitions SHALL be: any -> SERVE on a grant; any -> BLOCKED when non-empty inputs exist but none eligible or active=0; any -> IDLE when all empty.
REQ-022 idle SHALL be 1 in a cycle only if the FSM is in IDLE and no push is asserted that cycle.
REQ-023 active falling mid-transfer SHALL stop new pops the same cycle; the already-captured word SHALL still be pushed.
REQ-024 almost_full rising in the same cycle as a candidate grant SHALL block that grant (combinational check).

Reset
REQ-025 With reset=1 at a rising edge: push4..7 = 0, data_out = 0, idle = 1, FSM = IDLE, next cycle.
REQ-026 While reset=1, pop0..3 SHALL be 0 regardless of other inputs.
REQ-027 Reset mid-operation SHALL discard the in-flight word (no push the following cycle).

Verification
REQ-028 Reset then active=1, empty0..3=1 -> pop all 0, push all 0, idle=1, data_out=0.
REQ-029 Inputs 0..3 heads 10'h001, 10'h101, 10'h201, 10'h301 all non-empty, no almost_full -> pops in order 0,1,2,3 over 4 cycles (each held non-empty for one grant); push4,5,6,7 with data_out 001,101,201,301 one cycle later each.
REQ-030 Input 0 head 10'h101 with almost_full5=1, input 1 head 10'h002 -> pop1, push4 with data_out 10'h002; pop0 stays 0 until almost_full5 falls, then pop0 and push5 with 10'h101.
REQ-031 Four words per input, all 16 source/destination combinations, output FIFOs drained -> 16 pushes, each word on push_(4+bits[9:8]), per-input order preserved, idle=1 after last push.
REQ-032 active dropped in the cycle after pop0 with word 10'h3FF -> push7 with 10'h3FF next cycle, then no pops until active=1; FSM in BLOCKED, idle=0.
REQ-033 reset asserted in the cycle of pop2 (head 10'h2AA) -> no push6 in the next cycle, data_out=0, idle=1.
